// File: rtl/wb_port_scheduler.sv
// Write-back port owner: picks the write-back source and splits a 64-bit multiply into LO/HI writes.
// Optional WB_PERF_EN adds wr_count/stall_count performance counters.
module wb_port_scheduler #(
  parameter int WORD_LEN     = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_en,
  input  logic                    mem_r_en,
  input  logic                    mul_en,
  input  logic                    comp_en,
  input  logic [REG_ADDR_LEN-1:0] dest,
  input  logic [WORD_LEN-1:0]     alu_res,
  input  logic [WORD_LEN-1:0]     mem_read_val,
  input  logic [WORD_LEN-1:0]     high,
  output logic                    rf_we,
  output logic [REG_ADDR_LEN-1:0] rf_waddr,
  output logic [WORD_LEN-1:0]     rf_wdata,
  output logic                    stall,
`ifdef WB_PERF_EN
  output logic [CNT_W-1:0]        wr_count,
  output logic [CNT_W-1:0]        stall_count,
`endif
  output logic                    hi_pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HI_WR = 2'd1
  } state_t;

  state_t                    state_q, state_d;
  logic [WORD_LEN-1:0]       hi_buf_q, hi_buf_d;
  logic [REG_ADDR_LEN-1:0]   hi_addr_q, hi_addr_d;
  logic                      hi_pending_q, hi_pending_d;

  logic                      we_raw;
  logic [REG_ADDR_LEN-1:0]   waddr_raw;
  logic [WORD_LEN-1:0]       wdata_raw;
  logic                      stall_raw;
  logic                      mul_go;

  assign mul_go = wb_en & mul_en & ~mem_r_en;

  always_comb begin
    state_d      = state_q;
    hi_buf_d     = hi_buf_q;
    hi_addr_d    = hi_addr_q;
    hi_pending_d = hi_pending_q;
    we_raw       = 1'b0;
    waddr_raw    = '0;
    wdata_raw    = '0;
    stall_raw    = 1'b0;

    case (state_q)
      IDLE: begin
        we_raw    = wb_en & (dest != '0);
        waddr_raw = dest;
        if (mem_r_en)
          wdata_raw = mem_read_val;
        else if (mul_go)
          wdata_raw = alu_res;
        else if (comp_en)
          wdata_raw = {{(WORD_LEN-1){1'b0}}, alu_res[0]};
        else
          wdata_raw = alu_res;

        if (mul_go) begin
          stall_raw    = 1'b1;
          hi_buf_d     = high;
          hi_addr_d    = dest + REG_ADDR_LEN'(1);
          state_d      = HI_WR;
          hi_pending_d = 1'b1;
        end
      end

      HI_WR: begin
        // Upstream is frozen on the same multiply, so inputs are ignored here.
        we_raw       = (hi_addr_q != '0);
        waddr_raw    = hi_addr_q;
        wdata_raw    = hi_buf_q;
        state_d      = IDLE;
        hi_pending_d = 1'b0;
      end

      default: begin
        state_d      = IDLE;
        hi_pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hi_buf_q     <= '0;
      hi_addr_q    <= '0;
      hi_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_buf_q     <= hi_buf_d;
      hi_addr_q    <= hi_addr_d;
      hi_pending_q <= hi_pending_d;
    end
  end

  // Reset masks every output, including a half-finished HI write.
  assign rf_we      = we_raw & ~rst;
  assign rf_waddr   = rst ? '0 : waddr_raw;
  assign rf_wdata   = rst ? '0 : wdata_raw;
  assign stall      = stall_raw & ~rst;
  assign hi_pending = hi_pending_q & ~rst;

`ifdef WB_PERF_EN
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    wr_count_d    = wr_count_q;
    stall_count_d = stall_count_q;
    if (rf_we)
      wr_count_d = wr_count_q + CNT_W'(1);
    if (stall)
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      wr_count_q    <= wr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign wr_count    = rst ? '0 : wr_count_q;
  assign stall_count = rst ? '0 : stall_count_q;
`endif

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler: hand-computed vectors for source select, multiply sequencing, r0/wrap and reset.
module tb_wb_port_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en, mem_r_en, mul_en, comp_en;
  logic [4:0]  dest;
  logic [31:0] alu_res, mem_read_val, high;
  logic        rf_we, stall, hi_pending;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_PERF_EN
  logic [31:0] wr_count, stall_count;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  wb_port_scheduler dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .mem_r_en(mem_r_en), .mul_en(mul_en),
    .comp_en(comp_en), .dest(dest), .alu_res(alu_res), .mem_read_val(mem_read_val),
    .high(high), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall(stall),
`ifdef WB_PERF_EN
    .wr_count(wr_count), .stall_count(stall_count),
`endif
    .hi_pending(hi_pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic m, input logic mu, input logic c,
                       input logic [4:0] d, input logic [31:0] a,
                       input logic [31:0] mv, input logic [31:0] h);
    wb_en = w; mem_r_en = m; mul_en = mu; comp_en = c;
    dest = d; alu_res = a; mem_read_val = mv; high = h;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 0, 0, 0, 5'd3, 32'h1234, 32'h0, 32'h0);
    check("rst_we", {31'b0, rf_we}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    tick();
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_hi_pending", {31'b0, hi_pending}, 32'd0);
    tick();
    rst = 1'b0;

    drive(1, 0, 0, 0, 5'd3, 32'h0000_00AA, 32'h0, 32'h0);
    check("alu_we", {31'b0, rf_we}, 32'd1);
    check("alu_waddr", {27'b0, rf_waddr}, 32'd3);
    check("alu_wdata", rf_wdata, 32'h0000_00AA);
    check("alu_stall", {31'b0, stall}, 32'd0);

    tick();
    drive(1, 1, 0, 1, 5'd7, 32'h5, 32'hDEAD_BEEF, 32'h0);
    check("ld_over_cmp_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("ld_waddr", {27'b0, rf_waddr}, 32'd7);
    tick();
    drive(1, 0, 0, 1, 5'd7, 32'h5, 32'hDEAD_BEEF, 32'h0);
    check("cmp_wdata", rf_wdata, 32'h1);

    tick();
    drive(1, 0, 1, 0, 5'd4, 32'h1111_1111, 32'h0, 32'h2222_2222);
    check("mul_lo_we", {31'b0, rf_we}, 32'd1);
    check("mul_lo_waddr", {27'b0, rf_waddr}, 32'd4);
    check("mul_lo_wdata", rf_wdata, 32'h1111_1111);
    check("mul_lo_stall", {31'b0, stall}, 32'd1);
    check("mul_lo_hi_pending", {31'b0, hi_pending}, 32'd0);
    tick();
    check("mul_hi_we", {31'b0, rf_we}, 32'd1);
    check("mul_hi_waddr", {27'b0, rf_waddr}, 32'd5);
    check("mul_hi_wdata", rf_wdata, 32'h2222_2222);
    check("mul_hi_stall", {31'b0, stall}, 32'd0);
    check("mul_hi_pending", {31'b0, hi_pending}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 5'd4, 32'h0, 32'h0, 32'h0);
    check("mul_done_we", {31'b0, rf_we}, 32'd0);
    check("mul_done_pending", {31'b0, hi_pending}, 32'd0);

    tick();
    drive(1, 0, 1, 0, 5'd31, 32'hAAAA_0001, 32'h0, 32'hBBBB_0002);
    check("wrap_lo_waddr", {27'b0, rf_waddr}, 32'd31);
    check("wrap_lo_we", {31'b0, rf_we}, 32'd1);
    check("wrap_lo_stall", {31'b0, stall}, 32'd1);
    tick();
    check("wrap_hi_we", {31'b0, rf_we}, 32'd0);
    check("wrap_hi_pending", {31'b0, hi_pending}, 32'd1);
    tick();
    drive(1, 0, 0, 0, 5'd0, 32'h7777, 32'h0, 32'h0);
    check("r0_we", {31'b0, rf_we}, 32'd0);

    tick();
    drive(1, 1, 1, 0, 5'd6, 32'h9, 32'hCAFE_F00D, 32'h1);
    check("ldmul_wdata", rf_wdata, 32'hCAFE_F00D);
    check("ldmul_stall", {31'b0, stall}, 32'd0);
    tick();
    drive(0, 0, 1, 0, 5'd6, 32'h9, 32'h0, 32'h1);
    check("ldmul_no_pending", {31'b0, hi_pending}, 32'd0);
    check("mul_nowb_we", {31'b0, rf_we}, 32'd0);
    check("mul_nowb_stall", {31'b0, stall}, 32'd0);
    tick();
    check("mul_nowb_pending", {31'b0, hi_pending}, 32'd0);

    drive(1, 0, 1, 0, 5'd8, 32'h4444_4444, 32'h0, 32'h5555_5555);
    check("rmid_lo_stall", {31'b0, stall}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    check("rmid_we", {31'b0, rf_we}, 32'd0);
    check("rmid_stall", {31'b0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    check("rmid_after_pending", {31'b0, hi_pending}, 32'd0);
    check("rmid_after_we", {31'b0, rf_we}, 32'd0);
    tick();
    drive(1, 0, 0, 0, 5'd10, 32'h33, 32'h0, 32'h0);
    check("rmid_idle_waddr", {27'b0, rf_waddr}, 32'd10);
    check("rmid_idle_wdata", rf_wdata, 32'h33);
    check("rmid_idle_stall", {31'b0, stall}, 32'd0);

`ifdef WB_PERF_EN
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("perf_rst_wr", wr_count, 32'd0);
    check("perf_rst_stall", stall_count, 32'd0);
    drive(1, 0, 0, 0, 5'd1, 32'h1, 32'h0, 32'h0);
    tick();
    drive(1, 0, 0, 0, 5'd2, 32'h2, 32'h0, 32'h0);
    tick();
    drive(1, 0, 1, 0, 5'd4, 32'h3, 32'h0, 32'h4);
    tick();
    tick();
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    check("perf_wr", wr_count, 32'd4);
    check("perf_stall", stall_count, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("perf_clr_wr", wr_count, 32'd0);
    check("perf_clr_stall", stall_count, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/wb_port_scheduler.md
Name: wb_port_scheduler

Overview:
- Owns the single register-file write port at the write-back stage.
- Sits between the MEM/WB pipeline register outputs and the register file.
- Selects the write-back data source: ALU result, memory read value, or compare flag.
- A multiply produces a 64-bit result and needs two writes (LO, then HI). For a multiply, the block sequences the two writes over two cycles and stalls the upstream pipeline for one cycle.

Parameters:
WORD_LEN, 32, data word width
REG_ADDR_LEN, 5, register-file address width
CNT_W, 32, width of performance counters (used only when WB_PERF_EN is defined)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
wb_en  input  1  write-back enable from MEM/WB
mem_r_en  input  1  instruction is a load; write memory read value
mul_en  input  1  instruction is a multiply; two-cycle write-back
comp_en  input  1  instruction is a compare; write 0/1 flag
dest  input  REG_ADDR_LEN  destination register
alu_res  input  WORD_LEN  ALU result (LO word for a multiply)
mem_read_val  input  WORD_LEN  load data
high  input  WORD_LEN  HI word of the multiply
rf_we  output  1  register-file write enable
rf_waddr  output  REG_ADDR_LEN  register-file write address
rf_wdata  output  WORD_LEN  register-file write data
stall  output  1  freeze the IF..MEM/WB registers this cycle
hi_pending  output  1  registered; high while in state HI_WR

Behaviour:
- States: IDLE, HI_WR (2-bit encoding). Reset state is IDLE.
- Outputs rf_we, rf_waddr, rf_wdata and stall are combinational from state and inputs.
- While rst=1, all outputs are forced to 0. At the first clk edge with rst=1: state becomes IDLE, hi_buf/hi_addr clear to 0, hi_pending clears to 0.
- IDLE data select, in priority order:
  - mem_r_en=1 -> mem_read_val
  - else comp_en=1 -> {(WORD_LEN-1) zeros, alu_res[0]}
  - else alu_res
- IDLE write: rf_we = wb_en & (dest != 0); rf_waddr = dest. Writes to r0 are always suppressed.
- Multiply trigger in IDLE: wb_en=1 & mul_en=1 & mem_r_en=0. In that cycle:
  - LO write: alu_res to dest, subject to the r0 rule.
  - stall=1.
  - At the clk edge: hi_buf <= high, hi_addr <= dest+1 (modulo 2^REG_ADDR_LEN, so 31 wraps to 0), state <= HI_WR, hi_pending <= 1.
- mul_en with mem_r_en=1 is illegal. It is treated as a load: no HI write, no stall.
- mul_en with wb_en=0: no write, no stall.
- HI_WR, one cycle:
  - rf_we = (hi_addr != 0), rf_waddr = hi_addr, rf_wdata = hi_buf.
  - stall=0. All inputs are ignored, because upstream still holds the same multiply.
  - At the edge: state <= IDLE, hi_pending <= 0. The pipeline advances at this edge, so the multiply is never re-triggered.
- Multiply write-back latency: LO in cycle N, HI in cycle N+1. Back-to-back multiplies therefore cost 2 cycles each.
- Reset mid-operation: rst in HI_WR drops the pending HI write. The block is in IDLE on the next cycle.

Optional Feature:
- Macro: WB_PERF_EN.
- Defined:
  - Adds outputs wr_count and stall_count, each CNT_W bits, registered, reset to 0.
  - wr_count increments by 1 every cycle in which rf_we=1.
  - stall_count increments by 1 every cycle in which stall=1.
  - Both counters wrap at 2^CNT_W.
- Not defined: the ports and counter logic are absent. All other behaviour is identical.

Test Plan:
- ALU write: wb_en=1, dest=3, alu_res=0x0000_00AA -> same cycle rf_we=1, rf_waddr=3, rf_wdata=0xAA, stall=0.
- Load vs compare priority:
  - mem_r_en=1, comp_en=1, mem_read_val=0xDEAD_BEEF, dest=7 -> rf_wdata=0xDEADBEEF.
  - Next cycle mem_r_en=0, comp_en=1, alu_res=0x5 -> rf_wdata=0x1.
- Multiply: wb_en=1, mul_en=1, dest=4, alu_res=0x1111_1111, high=0x2222_2222 held two cycles ->
  - cycle N: write r4=0x11111111, stall=1.
  - cycle N+1: write r5=0x22222222, stall=0, hi_pending=1.
  - cycle N+2: IDLE.
- Wrap and r0 rule: multiply with dest=31 -> LO to r31; HI cycle has rf_we=0 (hi_addr=0). Separately, wb_en=1 with dest=0 -> rf_we=0.
- Reset mid-op: assert rst during HI_WR -> rf_we=0 and stall=0 that cycle; next cycle state IDLE, hi_pending=0, no HI write.
- WB_PERF_EN: two ALU writes plus one multiply to dest=4 -> wr_count=4, stall_count=1; rst clears both to 0.
